// File: rtl/nibbler_sequencer.sv
// nibbler_sequencer: phase/control sequencer for the Nibbler 4-bit datapath.
// Alternates FETCH and EXEC phases and decodes the latched opcode and flags
// into datapath strobes. Debug control covers run, single-step, halt request
// and a single PC breakpoint. Retired instructions are counted.

module nibbler_sequencer #(
  parameter int CNT_W    = 16,
  parameter bit BOOT_RUN = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             bkpt_en,
  input  logic [11:0]      bkpt_addr,
  input  logic [11:0]      pc,
  input  logic [3:0]       instr,
  input  logic             c_flag,
  input  logic             z_flag,
  output logic             phase,
  output logic             incPC,
  output logic             loadPC,
  output logic             loadA,
  output logic             loadFlags,
  output logic [2:0]       S,
  output logic             csRAM,
  output logic             weRAM,
  output logic             oeALU,
  output logic             oeIN,
  output logic             oeOprnd,
  output logic             loadOut,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_PASS = 3'b010;
  localparam logic [2:0] ALU_ADD  = 3'b011;
  localparam logic [2:0] ALU_NAND = 3'b100;

  state_t state;
  state_t next_state;
  logic   bkpt_skip;
  logic   step_pend;
  logic   bkpt_hit;
  logic   two_byte;

  // The pc seen in EXEC is already post-increment, so a hit means the next
  // instruction to fetch sits at the breakpoint address. The first
  // instruction after leaving HALT is exempt, so a resume never re-triggers.
  assign bkpt_hit = bkpt_en && (pc == bkpt_addr) && !bkpt_skip;

  assign halted = (state == ST_HALT);

  // State register; the reset state selects between free-run and halted boot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= BOOT_RUN ? ST_FETCH : ST_HALT;
    end else begin
      state <= next_state;
    end
  end

  // Debug bookkeeping: step pending, breakpoint skip and retired count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bkpt_skip <= 1'b0;
      step_pend <= 1'b0;
      instr_cnt <= '0;
    end else begin
      case (state)
        ST_HALT: begin
          if (next_state == ST_FETCH) begin
            bkpt_skip <= 1'b1;
            step_pend <= step;
          end
        end
        ST_EXEC: begin
          instr_cnt <= instr_cnt + CNT_W'(1);
          step_pend <= 1'b0;
          bkpt_skip <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // Next-state selection; a single step takes priority over free-run.
  always_comb begin
    next_state = ST_HALT;
    case (state)
      ST_HALT: begin
        if (step || (run && !halt_req)) begin
          next_state = ST_FETCH;
        end
      end
      ST_FETCH: begin
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        if (halt_req || step_pend) begin
          next_state = ST_HALT;
        end else if (bkpt_hit) begin
          next_state = ST_HALT;
        end else if (run) begin
          next_state = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_HALT;
      end
    endcase
  end

  // Opcodes that carry a second byte must skip it unless the PC is reloaded.
  always_comb begin
    two_byte = 1'b0;
    case (instr)
      4'h0, 4'h1, 4'h3, 4'h6, 4'h7,
      4'h8, 4'h9, 4'hB, 4'hC, 4'hF: two_byte = 1'b1;
      default: two_byte = 1'b0;
    endcase
  end

  // Datapath strobes decoded straight from state, opcode and flags.
  always_comb begin
    phase     = 1'b0;
    incPC     = 1'b0;
    loadPC    = 1'b0;
    loadA     = 1'b0;
    loadFlags = 1'b0;
    S         = ALU_NONE;
    csRAM     = 1'b0;
    weRAM     = 1'b0;
    oeALU     = 1'b0;
    oeIN      = 1'b0;
    oeOprnd   = 1'b0;
    loadOut   = 1'b0;
    case (state)
      ST_FETCH: begin
        incPC = 1'b1;
      end
      ST_EXEC: begin
        phase = 1'b1;
        case (instr)
          4'h0: loadPC = c_flag;
          4'h1: loadPC = !c_flag;
          4'h2: begin S = ALU_SUB;  oeOprnd = 1'b1; loadFlags = 1'b1; end
          4'h3: begin S = ALU_SUB;  csRAM = 1'b1;   loadFlags = 1'b1; end
          4'h4: begin S = ALU_PASS; oeOprnd = 1'b1; loadA = 1'b1; end
          4'h5: begin S = ALU_PASS; oeIN = 1'b1;    loadA = 1'b1; end
          4'h6: begin S = ALU_PASS; csRAM = 1'b1;   loadA = 1'b1; end
          4'h7: begin csRAM = 1'b1; weRAM = 1'b1;   oeALU = 1'b1; end
          4'h8: loadPC = z_flag;
          4'h9: loadPC = !z_flag;
          4'hA: begin S = ALU_ADD;  oeOprnd = 1'b1; loadA = 1'b1; loadFlags = 1'b1; end
          4'hB: begin S = ALU_ADD;  csRAM = 1'b1;   loadA = 1'b1; loadFlags = 1'b1; end
          4'hC: loadPC = 1'b1;
          4'hD: begin oeALU = 1'b1; loadOut = 1'b1; end
          4'hE: begin S = ALU_NAND; oeOprnd = 1'b1; loadA = 1'b1; loadFlags = 1'b1; end
          4'hF: begin S = ALU_NAND; csRAM = 1'b1;   loadA = 1'b1; loadFlags = 1'b1; end
          default: begin
          end
        endcase
        incPC = two_byte && !loadPC;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// tb_nibbler_sequencer: directed self-checking bench for nibbler_sequencer.
// Strobe vector order: phase incPC loadPC loadA loadFlags S[2:0]
//                      csRAM weRAM oeALU oeIN oeOprnd loadOut halted
`timescale 1ns/1ps

module tb_nibbler_sequencer;

  logic        clock;
  logic        reset;
  logic        run;
  logic        step;
  logic        halt_req;
  logic        bkpt_en;
  logic [11:0] bkpt_addr;
  logic [11:0] pc;
  logic [3:0]  instr;
  logic        c_flag;
  logic        z_flag;
  logic        phase;
  logic        incPC;
  logic        loadPC;
  logic        loadA;
  logic        loadFlags;
  logic [2:0]  S;
  logic        csRAM;
  logic        weRAM;
  logic        oeALU;
  logic        oeIN;
  logic        oeOprnd;
  logic        loadOut;
  logic        halted;
  logic [15:0] instr_cnt;

  logic [14:0] strobes;
  int          tests_run;
  int          tests_failed;
  logic        pc_auto;

  assign strobes = {phase, incPC, loadPC, loadA, loadFlags, S,
                    csRAM, weRAM, oeALU, oeIN, oeOprnd, loadOut, halted};

  nibbler_sequencer #(
    .CNT_W    (16),
    .BOOT_RUN (1'b0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .halt_req  (halt_req),
    .bkpt_en   (bkpt_en),
    .bkpt_addr (bkpt_addr),
    .pc        (pc),
    .instr     (instr),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .phase     (phase),
    .incPC     (incPC),
    .loadPC    (loadPC),
    .loadA     (loadA),
    .loadFlags (loadFlags),
    .S         (S),
    .csRAM     (csRAM),
    .weRAM     (weRAM),
    .oeALU     (oeALU),
    .oeIN      (oeIN),
    .oeOprnd   (oeOprnd),
    .loadOut   (loadOut),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Advance one clock; optionally move the bench's program counter the way
  // the datapath would, using the strobes that were valid before the edge.
  task automatic tick();
    logic inc;
    logic ld;
    inc = incPC;
    ld  = loadPC;
    @(posedge clock);
    #1;
    if (pc_auto && !ld && inc) pc = pc + 12'd1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clock);
    @(posedge clock);
    #1;
    tests_run++;
    if (strobes !== 15'b0_0_0_0_0_000_0_0_0_0_0_0_1) begin
      tests_failed++;
      $display("[TB] FAIL reset_strobes got %b want %b", strobes, 15'b0_0_0_0_0_000_0_0_0_0_0_0_1);
    end
    tests_run++;
    if (instr_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_cnt got %0d want 0", instr_cnt);
    end
    reset = 1'b0;
  endtask

  task automatic test_lit_run();
    instr = 4'h4;
    run   = 1'b1;
    tick();
    tests_run++;
    if (strobes !== 15'b0_1_0_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL lit_fetch got %b want %b", strobes, 15'b0_1_0_0_0_000_0_0_0_0_0_0_0);
    end
    tick();
    tests_run++;
    if (strobes !== 15'b1_0_0_1_0_010_0_0_0_0_1_0_0 || instr_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL lit_exec got %b cnt %0d want %b cnt 0", strobes, instr_cnt, 15'b1_0_0_1_0_010_0_0_0_0_1_0_0);
    end
    tick();
    tests_run++;
    if (phase !== 1'b0 || instr_cnt !== 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL lit_cnt1 got phase %b cnt %0d want phase 0 cnt 1", phase, instr_cnt);
    end
    tick();
    tick();
    tests_run++;
    if (phase !== 1'b0 || instr_cnt !== 16'd2) begin
      tests_failed++;
      $display("[TB] FAIL lit_cnt2 got phase %b cnt %0d want phase 0 cnt 2", phase, instr_cnt);
    end
    run = 1'b0;
    tick();
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== 16'd3) begin
      tests_failed++;
      $display("[TB] FAIL lit_stop got halted %b cnt %0d want halted 1 cnt 3", halted, instr_cnt);
    end
  endtask

  task automatic test_decode();
    pc_auto = 1'b0;
    instr   = 4'h0;
    c_flag  = 1'b1;
    run     = 1'b1;
    tick();
    run = 1'b0;
    tick();
    tests_run++;
    if (strobes !== 15'b1_0_1_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jc_taken got %b want %b", strobes, 15'b1_0_1_0_0_000_0_0_0_0_0_0_0);
    end
    c_flag = 1'b0;
    #1;
    tests_run++;
    if (strobes !== 15'b1_1_0_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jc_not_taken got %b want %b", strobes, 15'b1_1_0_0_0_000_0_0_0_0_0_0_0);
    end
    instr = 4'h1;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_1_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jnc_taken got %b want %b", strobes, 15'b1_0_1_0_0_000_0_0_0_0_0_0_0);
    end
    instr  = 4'h8;
    z_flag = 1'b1;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_1_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jz_taken got %b want %b", strobes, 15'b1_0_1_0_0_000_0_0_0_0_0_0_0);
    end
    z_flag = 1'b0;
    #1;
    tests_run++;
    if (strobes !== 15'b1_1_0_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jz_not_taken got %b want %b", strobes, 15'b1_1_0_0_0_000_0_0_0_0_0_0_0);
    end
    instr = 4'hC;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_1_0_0_000_0_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL jmp got %b want %b", strobes, 15'b1_0_1_0_0_000_0_0_0_0_0_0_0);
    end
    instr = 4'h7;
    #1;
    tests_run++;
    if (strobes !== 15'b1_1_0_0_0_000_1_1_1_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL st got %b want %b", strobes, 15'b1_1_0_0_0_000_1_1_1_0_0_0_0);
    end
    instr = 4'hD;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_0_0_0_000_0_0_1_0_0_1_0) begin
      tests_failed++;
      $display("[TB] FAIL out got %b want %b", strobes, 15'b1_0_0_0_0_000_0_0_1_0_0_1_0);
    end
    instr = 4'hB;
    #1;
    tests_run++;
    if (strobes !== 15'b1_1_0_1_1_011_1_0_0_0_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL addm got %b want %b", strobes, 15'b1_1_0_1_1_011_1_0_0_0_0_0_0);
    end
    instr = 4'h5;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_0_1_0_010_0_0_0_1_0_0_0) begin
      tests_failed++;
      $display("[TB] FAIL in got %b want %b", strobes, 15'b1_0_0_1_0_010_0_0_0_1_0_0_0);
    end
    instr = 4'h2;
    #1;
    tests_run++;
    if (strobes !== 15'b1_0_0_0_1_001_0_0_0_0_1_0_0) begin
      tests_failed++;
      $display("[TB] FAIL cmpi got %b want %b", strobes, 15'b1_0_0_0_1_001_0_0_0_0_1_0_0);
    end
    instr = 4'h4;
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== 16'd4) begin
      tests_failed++;
      $display("[TB] FAIL decode_stop got halted %b cnt %0d want halted 1 cnt 4", halted, instr_cnt);
    end
  endtask

  task automatic test_step();
    step = 1'b1;
    tick();
    step = 1'b0;
    tests_run++;
    if (phase !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL step_fetch got phase %b halted %b want 0 0", phase, halted);
    end
    tick();
    tests_run++;
    if (phase !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL step_exec got phase %b want 1", phase);
    end
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== 16'd5) begin
      tests_failed++;
      $display("[TB] FAIL step_done got halted %b cnt %0d want halted 1 cnt 5", halted, instr_cnt);
    end
    step = 1'b1;
    run  = 1'b1;
    tick();
    step = 1'b0;
    tick();
    run = 1'b0;
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== 16'd6) begin
      tests_failed++;
      $display("[TB] FAIL step_over_run got halted %b cnt %0d want halted 1 cnt 6", halted, instr_cnt);
    end
  endtask

  task automatic test_breakpoint();
    int  n;
    bit  saw_halt;
    pc        = 12'h000;
    pc_auto   = 1'b1;
    instr     = 4'h4;
    bkpt_en   = 1'b1;
    bkpt_addr = 12'h006;
    run       = 1'b1;
    tick();
    n = 0;
    while (halted !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    tests_run++;
    if (halted !== 1'b1 || pc !== 12'h006 || instr_cnt !== 16'd12) begin
      tests_failed++;
      $display("[TB] FAIL bkpt_hit got halted %b pc %h cnt %0d want halted 1 pc 006 cnt 12", halted, pc, instr_cnt);
    end
    tick();
    saw_halt = (halted !== 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (halted !== 1'b0) saw_halt = 1'b1;
    end
    tests_run++;
    if (saw_halt) begin
      tests_failed++;
      $display("[TB] FAIL bkpt_resume got re-halt 1 want 0 (pc %h)", pc);
    end
    run = 1'b0;
    n = 0;
    while (halted !== 1'b1 && n < 4) begin
      tick();
      n++;
    end
    pc_auto = 1'b0;
    pc      = 12'h006;
    run     = 1'b1;
    tick();
    tick();
    tick();
    tests_run++;
    if (phase !== 1'b0 || halted !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bkpt_skip got phase %b halted %b want 0 0", phase, halted);
    end
    tick();
    tick();
    tests_run++;
    if (halted !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bkpt_rearm got halted %b want 1", halted);
    end
    run     = 1'b0;
    bkpt_en = 1'b0;
  endtask

  task automatic test_halt_req();
    logic [15:0] cnt_before;
    run = 1'b1;
    tick();
    halt_req   = 1'b1;
    cnt_before = instr_cnt;
    tick();
    halt_req = 1'b0;
    run      = 1'b0;
    tests_run++;
    if (phase !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL halt_req_exec got phase %b want 1", phase);
    end
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== cnt_before + 16'd1) begin
      tests_failed++;
      $display("[TB] FAIL halt_req_stop got halted %b cnt %0d want halted 1 cnt %0d", halted, instr_cnt, cnt_before + 16'd1);
    end
  endtask

  task automatic test_reset_in_exec();
    instr = 4'h7;
    run   = 1'b1;
    tick();
    tick();
    tests_run++;
    if (csRAM !== 1'b1 || weRAM !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL st_before_reset got cs %b we %b want 1 1", csRAM, weRAM);
    end
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (strobes !== 15'b0_0_0_0_0_000_0_0_0_0_0_0_1 || instr_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_exec got %b cnt %0d want %b cnt 0", strobes, instr_cnt, 15'b0_0_0_0_0_000_0_0_0_0_0_0_1);
    end
    run   = 1'b0;
    reset = 1'b0;
    tick();
    tests_run++;
    if (halted !== 1'b1 || instr_cnt !== 16'd0) begin
      tests_failed++;
      $display("[TB] FAIL after_reset got halted %b cnt %0d want 1 0", halted, instr_cnt);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    pc_auto      = 1'b0;
    reset        = 1'b1;
    run          = 1'b0;
    step         = 1'b0;
    halt_req     = 1'b0;
    bkpt_en      = 1'b0;
    bkpt_addr    = 12'h000;
    pc           = 12'h000;
    instr        = 4'h0;
    c_flag       = 1'b0;
    z_flag       = 1'b0;
    test_reset();
    test_lit_run();
    test_decode();
    test_step();
    test_breakpoint();
    test_halt_req();
    test_reset_in_exec();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
